// File: rtl/hot_bit_encoder.sv
// Registered one-hot to binary encoder with valid/ready output stage and input validation.
// Define HOT_BIT_ERRCNT_EN to build the saturating error counter (err_clr/err_count ports).
module hot_bit_encoder #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef HOT_BIT_ERRCNT_EN
    input  logic                       err_clr,
    output logic [CNT_W-1:0]           err_count,
`endif
    input  logic [DEPTH-1:0]           in_vec,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [$clog2(DEPTH)-1:0]   out_index,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_err,
    output logic                       out_zero
);

    localparam int unsigned BITS = $clog2(DEPTH);

    logic            accept;
    logic            pop;
    logic [BITS-1:0] enc_index;
    logic            enc_zero;
    logic            enc_multi;
    logic            enc_err;

    logic            out_valid_q, out_valid_d;
    logic [BITS-1:0] out_index_q, out_index_d;
    logic            out_err_q,   out_err_d;
    logic            out_zero_q,  out_zero_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid_q && out_ready;

    // Scan from the top so the lowest set bit wins on multi-hot inputs.
    always_comb begin
        enc_index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (in_vec[i]) begin
                enc_index = BITS'(i);
            end
        end
    end

    assign enc_zero  = ~|in_vec;
    assign enc_multi = |(in_vec & (in_vec - DEPTH'(1)));
    assign enc_err   = enc_zero || enc_multi;

    always_comb begin
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_err_d   = out_err_q;
        out_zero_d  = out_zero_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_index_d = enc_index;
            out_err_d   = enc_err;
            out_zero_d  = enc_zero;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_err_q   <= 1'b0;
            out_zero_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_err_q   <= out_err_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_err   = out_err_q;
    assign out_zero  = out_zero_q;

`ifdef HOT_BIT_ERRCNT_EN
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Clear takes priority over a coincident erroneous accept.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr) begin
            err_count_d = '0;
        end else if (accept && enc_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_hot_bit_encoder.sv
// Directed self-checking bench for hot_bit_encoder (DEPTH=8); counter checks only
// when HOT_BIT_ERRCNT_EN is defined, with CNT_W=2 to reach saturation quickly.
module tb_hot_bit_encoder;

    logic       clk;
    logic       rst;
    logic [7:0] in_vec;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out_index;
    logic       out_valid;
    logic       out_ready;
    logic       out_err;
    logic       out_zero;
`ifdef HOT_BIT_ERRCNT_EN
    logic       err_clr;
    logic [1:0] err_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

`ifdef HOT_BIT_ERRCNT_EN
    hot_bit_encoder #(
        .DEPTH(8),
        .CNT_W(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .err_clr  (err_clr),
        .err_count(err_count),
        .in_vec   (in_vec),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_index(out_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_err  (out_err),
        .out_zero (out_zero)
    );
`else
    hot_bit_encoder #(
        .DEPTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vec   (in_vec),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_index(out_index),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_err  (out_err),
        .out_zero (out_zero)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_out(input string tag, input logic v, input logic [2:0] idx,
                             input logic err, input logic zero);
        check_eq({tag, " valid"}, 32'(out_valid), 32'(v));
        check_eq({tag, " index"}, 32'(out_index), 32'(idx));
        check_eq({tag, " err"},   32'(out_err),   32'(err));
        check_eq({tag, " zero"},  32'(out_zero),  32'(zero));
    endtask

    logic [7:0] vec;

    initial begin
        rst       = 1'b1;
        in_vec    = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef HOT_BIT_ERRCNT_EN
        err_clr   = 1'b0;
`endif
        #1;
        check_out("reset", 1'b0, 3'd0, 1'b0, 1'b0);
        check_eq("reset in_ready", 32'(in_ready), 32'd1);
`ifdef HOT_BIT_ERRCNT_EN
        check_eq("reset err_count", 32'(err_count), 32'd0);
`endif
        step();
        rst = 1'b0;
        step();

        // Single one-hot vector
        in_vec = 8'b0010_0000; in_valid = 1'b1; out_ready = 1'b1;
        step();
        check_out("single", 1'b1, 3'd5, 1'b0, 1'b0);

        // Back-to-back sweep, full throughput
        for (int i = 0; i < 8; i++) begin
            vec = 8'h01 << i;
            in_vec = vec;
            #1 check_eq("sweep in_ready", 32'(in_ready), 32'd1);
            step();
            check_eq("sweep valid", 32'(out_valid), 32'd1);
            check_eq("sweep index", 32'(out_index), 32'(i));
        end
        in_valid = 1'b0;
        step();
        check_eq("pop valid", 32'(out_valid), 32'd0);

        // Backpressure
        in_vec = 8'h04; in_valid = 1'b1;
        step();
        out_ready = 1'b0; in_vec = 8'h80;
        for (int c = 0; c < 3; c++) begin
            #1 check_eq("bp in_ready", 32'(in_ready), 32'd0);
            step();
            check_out("bp hold", 1'b1, 3'd2, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1 check_eq("bp release in_ready", 32'(in_ready), 32'd1);
        step();
        check_out("bp release", 1'b1, 3'd7, 1'b0, 1'b0);

        // Error vectors
        in_vec = 8'h00;
        step();
        check_out("zero-hot", 1'b1, 3'd0, 1'b1, 1'b1);
        in_vec = 8'h48;
        step();
        check_out("multi 48", 1'b1, 3'd3, 1'b1, 1'b0);
`ifdef HOT_BIT_ERRCNT_EN
        check_eq("err_count 2", 32'(err_count), 32'd2);
`endif
        in_vec = 8'hC0;
        step();
        check_out("multi C0", 1'b1, 3'd6, 1'b1, 1'b0);
        in_vec = 8'hFF;
        step();
        check_out("multi FF", 1'b1, 3'd0, 1'b1, 1'b0);
        in_vec = 8'h03;
        step();
        check_out("multi 03", 1'b1, 3'd0, 1'b1, 1'b0);
`ifdef HOT_BIT_ERRCNT_EN
        check_eq("err_count sat", 32'(err_count), 32'd3);
        in_vec = 8'h81; err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check_eq("err_clr wins", 32'(err_count), 32'd0);
        check_out("multi 81", 1'b1, 3'd0, 1'b1, 1'b0);
`endif
        in_valid = 1'b0;
        step();
        check_eq("err pop valid", 32'(out_valid), 32'd0);

        // Async reset while a result is held under backpressure
        in_vec = 8'h00; in_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check_eq("pre-rst valid", 32'(out_valid), 32'd1);
`ifdef HOT_BIT_ERRCNT_EN
        check_eq("pre-rst err_count", 32'(err_count), 32'd1);
`endif
        #2 rst = 1'b1;
        #1;
        check_out("async rst", 1'b0, 3'd0, 1'b0, 1'b0);
        check_eq("async rst in_ready", 32'(in_ready), 32'd1);
`ifdef HOT_BIT_ERRCNT_EN
        check_eq("async rst err_count", 32'(err_count), 32'd0);
`endif
        step();
        rst = 1'b0;
        step();
        check_eq("post-rst valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
